vend_txn_ctrl: RTL and testbench

- Transaction controller for the coin vending datapath.
- Accumulates coin credit and matches a product selection against a per-product price.
- Sequences the product dispenser via a req/ack handshake, then pays change one coin at a time via a second req/ack handshake.
- Sits between the coin acceptor/keypad front end and the dispense/change actuators.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_chg_seq.sv | 91 +++++++++
 rtl/vend_txn_ctrl.sv | 168 ++++++++++++++++
 tb/tb_vend_txn_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending transaction controller:
// top-level state encoding, coin codes and price lookup.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } state_t;

    localparam logic [1:0] COIN_5  = 2'b01;
    localparam logic [1:0] COIN_10 = 2'b10;

    // Credit units carried by a coin code; 0 marks an invalid code.
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  return 2'd1;
            COIN_10: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic int price_of(input logic [1:0] id, input int p0, input int p1,
                                    input int p2, input int p3);
        case (id)
            2'd0:    return p0;
            2'd1:    return p1;
            2'd2:    return p2;
            default: return p3;
        endcase
    endfunction

endpackage

// File: rtl/vend_chg_seq.sv
// Change payout loop: loads the amount on start, pays the largest coin that
// fits one req/ack at a time with a one-cycle gap, and flags the final coin.
module vend_chg_seq
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CREDIT_W-1:0] amount,
    input  logic                chg_ack,
    output logic                chg_req,
    output logic [1:0]          chg_coin,
    output logic                paid,
    output logic                done
);

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_REQ  = 2'd1,
        C_GAP  = 2'd2
    } cstate_t;

    cstate_t             state, state_nx;
    logic [CREDIT_W-1:0] remaining, remaining_nx;
    logic                req_nx;
    logic [1:0]          coin_nx;
    logic [CREDIT_W:0]   units_w, left_w;

    function automatic logic [1:0] pick(input logic [CREDIT_W:0] amt);
        return (amt >= (CREDIT_W+1)'(2)) ? COIN_10 : COIN_5;
    endfunction

    // Kept apart from the next-state logic so the parent can consume them
    // without a combinational path back through amount.
    assign units_w = (CREDIT_W+1)'(coin_units(chg_coin));
    assign paid    = (state == C_REQ) && chg_ack;
    assign done    = paid && ({1'b0, remaining} == units_w);
    assign left_w  = {1'b0, remaining} - units_w;

    always_comb begin
        state_nx     = state;
        remaining_nx = remaining;
        req_nx       = chg_req;
        coin_nx      = chg_coin;
        case (state)
            C_IDLE: begin
                if (start && (amount != '0)) begin
                    remaining_nx = amount;
                    req_nx       = 1'b1;
                    coin_nx      = pick({1'b0, amount});
                    state_nx     = C_REQ;
                end
            end
            C_REQ: begin
                if (chg_ack) begin
                    req_nx       = 1'b0;
                    remaining_nx = left_w[CREDIT_W-1:0];
                    if (left_w == '0) begin
                        coin_nx  = 2'b00;
                        state_nx = C_IDLE;
                    end else begin
                        coin_nx  = pick(left_w);
                        state_nx = C_GAP;
                    end
                end
            end
            C_GAP: begin
                req_nx   = 1'b1;
                state_nx = C_REQ;
            end
            default: state_nx = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= C_IDLE;
            remaining <= '0;
            chg_req   <= 1'b0;
            chg_coin  <= 2'b00;
        end else begin
            state     <= state_nx;
            remaining <= remaining_nx;
            chg_req   <= req_nx;
            chg_coin  <= coin_nx;
        end
    end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: credit accumulation, selection/price match,
// dispense handshake and change payout. Define VEND_TIMEOUT_EN for COLLECT inactivity refund.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int CREDIT_W    = 5,
    parameter int MAX_CREDIT  = 20,
    parameter int PRICE0      = 1,
    parameter int PRICE1      = 2,
    parameter int PRICE2      = 3,
    parameter int PRICE3      = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    output logic                coin_accept,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    output logic                dispense_req,
    output logic [1:0]          dispense_id,
    input  logic                dispense_ack,
    output logic                chg_req,
    output logic [1:0]          chg_coin,
    input  logic                chg_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                short_funds,
    output logic                txn_done,
    output logic                busy
);

    if ((MAX_CREDIT >= (1 << CREDIT_W)) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("vend_txn_ctrl: MAX_CREDIT must fit in CREDIT_W bits and TIMEOUT_CYC must be >= 1");
    end

    localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

    state_t              state, state_nx;
    logic [CREDIT_W-1:0] credit_nx;
    logic [CREDIT_W:0]   cred_w, add_w, sum_w, price_w, paid_w, cred_nx_w;
    logic [1:0]          units_in, did_nx;
    logic                coin_ok, accept_nx, reject_nx, short_nx, done_nx, dreq_nx;
    logic                chg_start, chg_paid, chg_done, cancel_eff, timeout;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmo_cnt <= '0;
        else if ((state != COLLECT) || coin_valid || sel_valid || cancel)
            tmo_cnt <= '0;
        else if (!timeout)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign timeout = (state == COLLECT) && (tmo_cnt == TMO_W'(TIMEOUT_CYC));
`else
    assign timeout = 1'b0;
`endif

    assign cancel_eff = cancel || timeout;
    assign units_in   = coin_units(coin_val);
    assign cred_w     = {1'b0, credit};
    assign sum_w      = cred_w + (CREDIT_W+1)'(units_in);
    assign price_w    = (CREDIT_W+1)'(price_of(sel_id, PRICE0, PRICE1, PRICE2, PRICE3));
    assign paid_w     = (CREDIT_W+1)'(coin_units(chg_coin));
    // Overflow is judged against the credit before any same-cycle price deduction.
    assign coin_ok    = coin_valid && (units_in != 2'd0) && (sum_w <= MAX_C) &&
                        ((state == IDLE) || (state == COLLECT));
    assign add_w      = coin_ok ? (CREDIT_W+1)'(units_in) : '0;

    always_comb begin
        state_nx  = state;
        cred_nx_w = cred_w;
        accept_nx = coin_ok;
        reject_nx = coin_valid && !coin_ok;
        short_nx  = 1'b0;
        done_nx   = 1'b0;
        dreq_nx   = dispense_req;
        did_nx    = dispense_id;
        chg_start = 1'b0;
        case (state)
            IDLE: begin
                cred_nx_w = cred_w + add_w;
                short_nx  = sel_valid;
                if (coin_ok) state_nx = COLLECT;
            end
            COLLECT: begin
                if (cancel_eff) begin
                    cred_nx_w = cred_w + add_w;
                    chg_start = (cred_nx_w != '0);
                    state_nx  = chg_start ? CHANGE : IDLE;
                end else if (sel_valid && (cred_w >= price_w)) begin
                    cred_nx_w = cred_w - price_w + add_w;
                    dreq_nx   = 1'b1;
                    did_nx    = sel_id;
                    state_nx  = DISPENSE;
                end else begin
                    cred_nx_w = cred_w + add_w;
                    short_nx  = sel_valid;
                end
            end
            DISPENSE: begin
                if (dispense_ack) begin
                    dreq_nx = 1'b0;
                    if (credit != '0) begin
                        chg_start = 1'b1;
                        state_nx  = CHANGE;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            CHANGE: begin
                if (chg_paid) cred_nx_w = cred_w - paid_w;
                if (chg_done) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        credit_nx = cred_nx_w[CREDIT_W-1:0];
    end

    vend_chg_seq #(.CREDIT_W(CREDIT_W)) u_chg_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (chg_start),
        .amount   (credit_nx),
        .chg_ack  (chg_ack),
        .chg_req  (chg_req),
        .chg_coin (chg_coin),
        .paid     (chg_paid),
        .done     (chg_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            credit       <= '0;
            coin_accept  <= 1'b0;
            coin_reject  <= 1'b0;
            short_funds  <= 1'b0;
            txn_done     <= 1'b0;
            dispense_req <= 1'b0;
            dispense_id  <= 2'b00;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            credit       <= credit_nx;
            coin_accept  <= accept_nx;
            coin_reject  <= reject_nx;
            short_funds  <= short_nx;
            txn_done     <= done_nx;
            dispense_req <= dreq_nx;
            dispense_id  <= did_nx;
            busy         <= (state_nx == DISPENSE) || (state_nx == CHANGE);
        end
    end

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl with hand-computed expectations;
// the refund-timeout scenario runs only when VEND_TIMEOUT_EN is defined.
module tb_vend_txn_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_val = 2'b00;
    logic       coin_accept, coin_reject;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'b00;
    logic       cancel = 1'b0;
    logic       dispense_req;
    logic [1:0] dispense_id;
    logic       dispense_ack = 1'b0;
    logic       chg_req;
    logic [1:0] chg_coin;
    logic       chg_ack = 1'b0;
    logic [4:0] credit;
    logic       short_funds, txn_done, busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vend_txn_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_val     (coin_val),
        .coin_accept  (coin_accept),
        .coin_reject  (coin_reject),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .cancel       (cancel),
        .dispense_req (dispense_req),
        .dispense_id  (dispense_id),
        .dispense_ack (dispense_ack),
        .chg_req      (chg_req),
        .chg_coin     (chg_coin),
        .chg_ack      (chg_ack),
        .credit       (credit),
        .short_funds  (short_funds),
        .txn_done     (txn_done),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] v);
        coin_valid = 1'b1;
        coin_val   = v;
        tick();
        coin_valid = 1'b0;
        coin_val   = 2'b00;
    endtask

    task automatic select(input logic [1:0] id);
        sel_valid = 1'b1;
        sel_id    = id;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    task automatic ack_dispense();
        dispense_ack = 1'b1;
        tick();
        dispense_ack = 1'b0;
    endtask

    task automatic ack_chg();
        chg_ack = 1'b1;
        tick();
        chg_ack = 1'b0;
    endtask

    // Acks every change coin until the transaction closes, within a cycle budget.
    task automatic drain(input string tag);
        for (int i = 0; i < 100 && !txn_done; i++) begin
            if (chg_req) chg_ack = 1'b1;
            tick();
            chg_ack = 1'b0;
        end
        check({tag, "_done"}, txn_done, 1);
        check({tag, "_credit"}, credit, 0);
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_credit", credit, 0);
        check("rst_dreq", dispense_req, 0);
        check("rst_chgreq", chg_req, 0);
        check("rst_busy", busy, 0);
        check("rst_accept", coin_accept, 0);
        rst_n = 1'b1;
        tick();

        // Selection in IDLE is refused
        select(2'd0);
        check("idle_sel_short", short_funds, 1);
        check("idle_sel_credit", credit, 0);

        // 10c, select product 1 (price 2): exact payment
        put_coin(2'b10);
        check("t1_accept", coin_accept, 1);
        check("t1_credit", credit, 2);
        select(2'd1);
        check("t1_dreq", dispense_req, 1);
        check("t1_did", dispense_id, 1);
        check("t1_credit0", credit, 0);
        check("t1_busy", busy, 1);
        tick(); tick();
        check("t1_dreq_hold", dispense_req, 1);
        ack_dispense();
        check("t1_dreq_drop", dispense_req, 0);
        check("t1_done", txn_done, 1);
        check("t1_nochg", chg_req, 0);
        tick();
        check("t1_done_pulse", txn_done, 0);

        // 20c, select product 0 (price 1): 10c then 5c change
        put_coin(2'b10);
        put_coin(2'b10);
        check("t2_credit4", credit, 4);
        select(2'd0);
        check("t2_credit3", credit, 3);
        check("t2_did", dispense_id, 0);
        ack_dispense();
        check("t2_chgreq", chg_req, 1);
        check("t2_coin10", chg_coin, 2);
        check("t2_busy", busy, 1);
        ack_chg();
        check("t2_gap", chg_req, 0);
        check("t2_credit1", credit, 1);
        check("t2_gap_coin", chg_coin, 1);
        tick();
        check("t2_chgreq2", chg_req, 1);
        check("t2_coin5", chg_coin, 1);
        ack_chg();
        check("t2_credit0", credit, 0);
        check("t2_done", txn_done, 1);
        check("t2_idle_busy", busy, 0);
        tick();

        // Short funds, then cancel refunds 5c
        put_coin(2'b01);
        select(2'd3);
        check("t3_short", short_funds, 1);
        check("t3_credit", credit, 1);
        check("t3_nodreq", dispense_req, 0);
        check("t3_notbusy", busy, 0);
        tick();
        check("t3_short_pulse", short_funds, 0);
        do_cancel();
        check("t3_chgreq", chg_req, 1);
        check("t3_coin5", chg_coin, 1);
        ack_chg();
        check("t3_done", txn_done, 1);
        check("t3_credit0", credit, 0);
        tick();

        // Credit ceiling and invalid coin codes
        for (int i = 0; i < 9; i++) put_coin(2'b10);
        put_coin(2'b01);
        check("t4_credit19", credit, 19);
        put_coin(2'b10);
        check("t4_rej_over", coin_reject, 1);
        check("t4_noacc_over", coin_accept, 0);
        check("t4_credit19b", credit, 19);
        put_coin(2'b01);
        check("t4_acc_max", coin_accept, 1);
        check("t4_credit20", credit, 20);
        put_coin(2'b01);
        check("t4_rej_full", coin_reject, 1);
        put_coin(2'b11);
        check("t4_rej_code", coin_reject, 1);
        check("t4_credit20b", credit, 20);
        do_cancel();
        check("t4_chgcoin", chg_coin, 2);
        drain("t4");

        // Selection and coin in the same cycle; coin refused during DISPENSE
        put_coin(2'b10);
        put_coin(2'b01);
        sel_valid  = 1'b1;
        sel_id     = 2'd2;
        coin_valid = 1'b1;
        coin_val   = 2'b01;
        tick();
        sel_valid  = 1'b0;
        coin_valid = 1'b0;
        coin_val   = 2'b00;
        check("t5_credit1", credit, 1);
        check("t5_dreq", dispense_req, 1);
        check("t5_did", dispense_id, 2);
        check("t5_acc", coin_accept, 1);
        put_coin(2'b10);
        check("t5_rej_disp", coin_reject, 1);
        check("t5_credit1b", credit, 1);
        ack_dispense();
        check("t5_chgcoin", chg_coin, 1);
        drain("t5");

`ifdef VEND_TIMEOUT_EN
        // Inactivity in COLLECT refunds the credit
        put_coin(2'b10);
        for (int i = 0; i < 1100 && !chg_req; i++) tick();
        check("tmo_chgreq", chg_req, 1);
        check("tmo_coin10", chg_coin, 2);
        ack_chg();
        check("tmo_done", txn_done, 1);
        check("tmo_credit", credit, 0);
        tick();
`endif

        // Asynchronous reset in the middle of a change payout
        put_coin(2'b10);
        put_coin(2'b10);
        do_cancel();
        ack_chg();
        tick();
        check("t6_chgreq_pre", chg_req, 1);
        check("t6_credit_pre", credit, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_chgreq_rst", chg_req, 0);
        check("t6_credit_rst", credit, 0);
        check("t6_busy_rst", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        put_coin(2'b01);
        check("t6_after_credit", credit, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
